// File: rtl/enemy_scheduler.sv
// Enemy spawn/retire/crash scheduler for a four-slot lane game.
// Spawns use an LFSR-picked lane, free slots retire at EXIT_Y, and a collision freezes play for CRASH_TICKS ticks.
module enemy_scheduler #(
    parameter int SPAWN_TICKS = 64,
    parameter int CRASH_TICKS = 128,
    parameter int LANE0_X     = 129,
    parameter int LANE1_X     = 193,
    parameter int LANE2_X     = 257,
    parameter int LANE3_X     = 321,
    parameter int SPAWN_Y     = 0,
    parameter int EXIT_Y      = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        logic_tick,
    input  logic        game_run,
    input  logic [3:0]  collision,
    input  logic [39:0] pos_y,
    output logic [3:0]  enable,
    output logic [39:0] offset_x,
    output logic [39:0] offset_y,
    output logic [3:0]  active,
    output logic        crash,
    output logic [7:0]  score
);

    localparam int SPAWN_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
    localparam int CRASH_W = (CRASH_TICKS > 1) ? $clog2(CRASH_TICKS) : 1;

    localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_TICKS - 1);
    localparam logic [CRASH_W-1:0] CRASH_LAST = CRASH_W'(CRASH_TICKS - 1);
    localparam logic [9:0]         EXIT_Y_L   = 10'(EXIT_Y);
    localparam logic [9:0]         SPAWN_Y_L  = 10'(SPAWN_Y);
    localparam logic [3:0][9:0]    LANE_X     = {10'(LANE3_X), 10'(LANE2_X),
                                                 10'(LANE1_X), 10'(LANE0_X)};
    localparam logic [7:0]         LFSR_SEED  = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [SPAWN_W-1:0]   spawn_cnt, spawn_cnt_nxt;
    logic [CRASH_W-1:0]   crash_cnt, crash_cnt_nxt;
    logic [7:0]           lfsr, lfsr_nxt;
    logic [1:0]           prev_lane, prev_lane_nxt;
    logic [3:0]           enable_q, enable_nxt;
    logic [3:0]           active_q, active_nxt;
    logic [3:0][9:0]      off_x_q, off_x_nxt;
    logic [3:0][9:0]      off_y_q, off_y_nxt;
    logic                 crash_q, crash_nxt;
    logic [7:0]           score_q, score_nxt;

    logic [3:0][9:0]      slot_y;
    logic [3:0]           retiring;
    logic [3:0]           free;
    logic                 hit;
    logic [1:0]           spawn_slot;
    logic [1:0]           spawn_lane;
    logic [2:0]           retire_cnt;
    logic [8:0]           score_sum;

    assign slot_y   = pos_y;
    assign free     = ~active_q;
    assign hit      = |(collision & active_q);
    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Never pick the same lane twice in a row.
    assign spawn_lane = (lfsr[1:0] == prev_lane) ? lfsr[1:0] + 2'd1 : lfsr[1:0];

    always_comb begin
        retiring = '0;
        for (int k = 0; k < 4; k++) begin
            retiring[k] = active_q[k] && (slot_y[k] >= EXIT_Y_L);
        end
    end

    always_comb begin
        spawn_slot = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (free[k]) begin
                spawn_slot = 2'(k);
            end
        end
    end

    assign retire_cnt = {2'b0, retiring[0]} + {2'b0, retiring[1]}
                      + {2'b0, retiring[2]} + {2'b0, retiring[3]};
    assign score_sum  = {1'b0, score_q} + {6'b0, retire_cnt};

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    always_comb begin
        state_nxt     = state;
        spawn_cnt_nxt = spawn_cnt;
        crash_cnt_nxt = crash_cnt;
        prev_lane_nxt = prev_lane;
        enable_nxt    = '0;
        active_nxt    = active_q;
        off_x_nxt     = off_x_q;
        off_y_nxt     = off_y_q;
        score_nxt     = score_q;

        unique case (state)
            IDLE: begin
                active_nxt    = '0;
                spawn_cnt_nxt = '0;
                crash_cnt_nxt = '0;
                if (game_run) begin
                    state_nxt = RUN;
                    score_nxt = '0;
                end
            end

            RUN: begin
                if (!game_run) begin
                    state_nxt     = IDLE;
                    active_nxt    = '0;
                    spawn_cnt_nxt = '0;
                end else if (hit) begin
                    state_nxt     = CRASH;
                    spawn_cnt_nxt = '0;
                    crash_cnt_nxt = '0;
                end else begin
                    active_nxt = active_q & ~retiring;
                    score_nxt  = score_sum[8] ? 8'hFF : score_sum[7:0];
                    if (logic_tick) begin
                        if (spawn_cnt != SPAWN_LAST) begin
                            spawn_cnt_nxt = spawn_cnt + 1'b1;
                        end else if (|free) begin
                            // Retiring slots are still active this cycle, so
                            // they are never picked as the spawn target.
                            spawn_cnt_nxt          = '0;
                            enable_nxt[spawn_slot] = 1'b1;
                            active_nxt[spawn_slot] = 1'b1;
                            off_x_nxt[spawn_slot]  = LANE_X[spawn_lane];
                            off_y_nxt[spawn_slot]  = SPAWN_Y_L;
                            prev_lane_nxt          = spawn_lane;
                        end
                    end
                end
            end

            CRASH: begin
                if (logic_tick) begin
                    if (crash_cnt == CRASH_LAST) begin
                        crash_cnt_nxt = '0;
                        active_nxt    = '0;
                        state_nxt     = game_run ? RUN : IDLE;
                    end else begin
                        crash_cnt_nxt = crash_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt  = IDLE;
                active_nxt = '0;
            end
        endcase

        crash_nxt = (state_nxt == CRASH);
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        // NOTE: this block holds only control and output flops (no storage
        // arrays), so all of it is reset to a known value.
        if (!reset) begin
            state     <= IDLE;
            spawn_cnt <= '0;
            crash_cnt <= '0;
            lfsr      <= LFSR_SEED;
            prev_lane <= 2'd0;
            enable_q  <= '0;
            active_q  <= '0;
            off_x_q   <= '0;
            off_y_q   <= '0;
            crash_q   <= 1'b0;
            score_q   <= '0;
        end else begin
            state     <= state_nxt;
            spawn_cnt <= spawn_cnt_nxt;
            crash_cnt <= crash_cnt_nxt;
            lfsr      <= lfsr_nxt;
            prev_lane <= prev_lane_nxt;
            enable_q  <= enable_nxt;
            active_q  <= active_nxt;
            off_x_q   <= off_x_nxt;
            off_y_q   <= off_y_nxt;
            crash_q   <= crash_nxt;
            score_q   <= score_nxt;
        end
    end

    assign enable   = enable_q;
    assign active   = active_q;
    assign offset_x = off_x_q;
    assign offset_y = off_y_q;
    assign crash    = crash_q;
    assign score    = score_q;

endmodule

// File: tb/tb_enemy_scheduler.sv
// Self-checking bench for enemy_scheduler: hand-computed vector table, corner
// sequences, and a randomized phase checked against a cycle model.
module tb_enemy_scheduler;

    localparam int SPAWN_TICKS = 64;
    localparam int CRASH_TICKS = 128;
    localparam int SPAWN_Y     = 0;
    localparam int EXIT_Y      = 480;

    logic        clk = 1'b0;
    logic        reset;
    logic        logic_tick;
    logic        game_run;
    logic [3:0]  collision;
    logic [39:0] pos_y;
    logic [3:0]  enable;
    logic [39:0] offset_x;
    logic [39:0] offset_y;
    logic [3:0]  active;
    logic        crash;
    logic [7:0]  score;

    int n_checks = 0;
    int n_fail   = 0;

    enemy_scheduler #(
        .SPAWN_TICKS(SPAWN_TICKS),
        .CRASH_TICKS(CRASH_TICKS),
        .LANE0_X(129),
        .LANE1_X(193),
        .LANE2_X(257),
        .LANE3_X(321),
        .SPAWN_Y(SPAWN_Y),
        .EXIT_Y(EXIT_Y)
    ) dut (
        .clk(clk),
        .reset(reset),
        .logic_tick(logic_tick),
        .game_run(game_run),
        .collision(collision),
        .pos_y(pos_y),
        .enable(enable),
        .offset_x(offset_x),
        .offset_y(offset_y),
        .active(active),
        .crash(crash),
        .score(score)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int lane_x(input int lane);
        case (lane)
            0:       return 129;
            1:       return 193;
            2:       return 257;
            default: return 321;
        endcase
    endfunction

    function automatic int lfsr_step(input int v);
        logic [7:0] b;
        b = 8'(v);
        // Polynomial x^8+x^6+x^5+x^4+1: taps on bits 8,6,5,4 (1-based).
        return int'({b[6:0], ^(b & 8'b1011_1000)});
    endfunction

    // ---------------- reference model ----------------
    bit       m_running, m_crashing;
    int       m_spawn_ticks, m_crash_ticks, m_lfsr, m_prev_lane, m_score;
    bit [3:0] m_active, m_enable;
    int       m_off_x[4], m_off_y[4];
    int       seen_last_x;

    task automatic model_step();
        bit [3:0] act_before;
        int       lfsr_before, n_ret, slot, lane;
        act_before  = m_active;
        lfsr_before = m_lfsr;
        m_enable    = '0;
        if (!reset) begin
            m_running     = 0;
            m_crashing    = 0;
            m_spawn_ticks = 0;
            m_crash_ticks = 0;
            m_lfsr        = 'hA5;
            m_prev_lane   = 0;
            m_score       = 0;
            m_active      = '0;
            for (int k = 0; k < 4; k++) begin
                m_off_x[k] = 0;
                m_off_y[k] = 0;
            end
            seen_last_x = lane_x(0);
            return;
        end
        m_lfsr = lfsr_step(m_lfsr);
        if (m_crashing) begin
            if (logic_tick) begin
                if (m_crash_ticks == CRASH_TICKS - 1) begin
                    m_crash_ticks = 0;
                    m_active      = '0;
                    m_crashing    = 0;
                    m_running     = game_run;
                end else begin
                    m_crash_ticks++;
                end
            end
        end else if (!m_running) begin
            m_active      = '0;
            m_spawn_ticks = 0;
            m_crash_ticks = 0;
            if (game_run) begin
                m_running = 1;
                m_score   = 0;
            end
        end else if (!game_run) begin
            m_running     = 0;
            m_active      = '0;
            m_spawn_ticks = 0;
        end else if ((collision & act_before) != 0) begin
            m_running     = 0;
            m_crashing    = 1;
            m_spawn_ticks = 0;
            m_crash_ticks = 0;
        end else begin
            n_ret = 0;
            for (int k = 0; k < 4; k++) begin
                if (act_before[k] && int'(pos_y[10*k +: 10]) >= EXIT_Y) begin
                    m_active[k] = 0;
                    n_ret++;
                end
            end
            m_score = (m_score + n_ret > 255) ? 255 : m_score + n_ret;
            if (logic_tick) begin
                if (m_spawn_ticks < SPAWN_TICKS - 1) begin
                    m_spawn_ticks++;
                end else begin
                    slot = -1;
                    for (int k = 3; k >= 0; k--) begin
                        if (!act_before[k]) slot = k;
                    end
                    if (slot >= 0) begin
                        lane = lfsr_before % 4;
                        if (lane == m_prev_lane) lane = (lane + 1) % 4;
                        m_prev_lane      = lane;
                        m_active[slot]   = 1;
                        m_enable[slot]   = 1;
                        m_off_x[slot]    = lane_x(lane);
                        m_off_y[slot]    = SPAWN_Y;
                        m_spawn_ticks    = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [39:0] ex_x, ex_y;
        int          x;
        for (int k = 0; k < 4; k++) begin
            ex_x[10*k +: 10] = 10'(m_off_x[k]);
            ex_y[10*k +: 10] = 10'(m_off_y[k]);
        end
        check("model_enable", 64'(enable), 64'(m_enable));
        check("model_active", 64'(active), 64'(m_active));
        check("model_crash", 64'(crash), 64'(m_crashing));
        check("model_score", 64'(score), 64'(m_score));
        check("model_offset_x", 64'(offset_x), 64'(ex_x));
        check("model_offset_y", 64'(offset_y), 64'(ex_y));
        for (int k = 0; k < 4; k++) begin
            if (enable[k] === 1'b1) begin
                x = int'(offset_x[10*k +: 10]);
                check("lane_repeat", 64'(x == seen_last_x), 64'(0));
                check("lane_valid", 64'(x == 129 || x == 193 || x == 257 || x == 321), 64'(1));
                seen_last_x = x;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic rst, input logic run, input logic tick,
                         input logic [3:0] col, input logic [39:0] py);
        reset      = rst;
        game_run   = run;
        logic_tick = tick;
        collision  = col;
        pos_y      = py;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        run;
        logic        tick;
        logic [3:0]  col;
        logic [39:0] py;
        int          n;
        logic [3:0]  exp_en;
        logic [3:0]  exp_act;
        logic        exp_crash;
        logic [7:0]  exp_score;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic run, input logic tick,
                                input logic [3:0] col, input logic [39:0] py, input int n,
                                input logic [3:0] en, input logic [3:0] act,
                                input logic cr, input logic [7:0] sc);
        vec_t v;
        v.rst = rst; v.run = run; v.tick = tick; v.col = col; v.py = py; v.n = n;
        v.exp_en = en; v.exp_act = act; v.exp_crash = cr; v.exp_score = sc;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [39:0] py_r;
        int          r, val;

        drive(1'b0, 1'b0, 1'b0, 4'b0, 40'b0);

        //          rst  run  tick col      pos_y                             n    en       act      cr   score
        vecs.push_back(mk(0, 0, 0, 4'b0000, 40'b0,                            2,   4'b0000, 4'b0000, 0, 8'd0));
        vecs.push_back(mk(1, 1, 0, 4'b0000, 40'b0,                            1,   4'b0000, 4'b0000, 0, 8'd0));
        vecs.push_back(mk(1, 1, 1, 4'b0000, 40'b0,                            63,  4'b0000, 4'b0000, 0, 8'd0));
        vecs.push_back(mk(1, 1, 1, 4'b0000, 40'b0,                            1,   4'b0001, 4'b0001, 0, 8'd0));
        vecs.push_back(mk(1, 1, 0, 4'b0000, 40'b0,                            1,   4'b0000, 4'b0001, 0, 8'd0));
        vecs.push_back(mk(1, 1, 1, 4'b0000, 40'b0,                            64,  4'b0010, 4'b0011, 0, 8'd0));
        vecs.push_back(mk(1, 1, 1, 4'b0000, 40'b0,                            128, 4'b1000, 4'b1111, 0, 8'd0));
        vecs.push_back(mk(1, 1, 1, 4'b0000, 40'b0,                            144, 4'b0000, 4'b1111, 0, 8'd0));
        vecs.push_back(mk(1, 1, 0, 4'b0000, {10'd0, 10'd0, 10'd480, 10'd0},   1,   4'b0000, 4'b1101, 0, 8'd1));
        vecs.push_back(mk(1, 1, 1, 4'b0000, 40'b0,                            1,   4'b0010, 4'b1111, 0, 8'd1));
        vecs.push_back(mk(1, 1, 1, 4'b0000, 40'b0,                            63,  4'b0000, 4'b1111, 0, 8'd1));
        vecs.push_back(mk(1, 1, 1, 4'b0100, 40'b0,                            1,   4'b0000, 4'b1111, 1, 8'd1));
        vecs.push_back(mk(1, 1, 1, 4'b0000, 40'b0,                            127, 4'b0000, 4'b1111, 1, 8'd1));
        vecs.push_back(mk(1, 1, 1, 4'b0000, 40'b0,                            1,   4'b0000, 4'b0000, 0, 8'd1));
        vecs.push_back(mk(1, 1, 0, 4'b1111, 40'b0,                            3,   4'b0000, 4'b0000, 0, 8'd1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].run, vecs[i].tick, vecs[i].col, vecs[i].py);
            repeat (vecs[i].n) step();
            check($sformatf("v%0d_enable", i), 64'(enable), 64'(vecs[i].exp_en));
            check($sformatf("v%0d_active", i), 64'(active), 64'(vecs[i].exp_act));
            check($sformatf("v%0d_crash", i),  64'(crash),  64'(vecs[i].exp_crash));
            check($sformatf("v%0d_score", i),  64'(score),  64'(vecs[i].exp_score));
        end

        // Dropping game_run mid-CRASH still waits out the full crash, then IDLE.
        drive(1'b1, 1'b1, 1'b1, 4'b0000, 40'b0);
        repeat (SPAWN_TICKS) step();
        check("crun_spawn_active", 64'(active), 64'(4'b0001));
        drive(1'b1, 1'b1, 1'b0, 4'b0001, 40'b0);
        step();
        check("crun_crash_enter", 64'(crash), 64'(1));
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 40'b0);
        repeat (CRASH_TICKS - 1) step();
        check("crun_crash_held", 64'(crash), 64'(1));
        step();
        check("crun_crash_done", 64'(crash), 64'(0));
        check("crun_active_clr", 64'(active), 64'(0));
        repeat (70) step();
        check("idle_no_spawn", 64'(active), 64'(0));
        check("idle_score_held", 64'(score), 64'(1));

        // Score saturation over 300 retires, then clear on the next run start.
        drive(1'b1, 1'b1, 1'b0, 4'b0000, 40'b0);
        step();
        check("run_score_clear", 64'(score), 64'(0));
        drive(1'b1, 1'b1, 1'b1, 4'b0000, {4{10'd480}});
        repeat (300 * SPAWN_TICKS + 4) step();
        check("score_saturated", 64'(score), 64'(255));
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 40'b0);
        step();
        check("stop_score_held", 64'(score), 64'(255));
        drive(1'b1, 1'b1, 1'b0, 4'b0000, 40'b0);
        step();
        check("restart_score_clear", 64'(score), 64'(0));

        // Reset on a terminal spawn tick: no spawn, no pulse after release.
        drive(1'b1, 1'b1, 1'b1, 4'b0000, 40'b0);
        repeat (SPAWN_TICKS - 1) step();
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 40'b0);
        step();
        check("rst_spawn_enable", 64'(enable), 64'(0));
        check("rst_spawn_active", 64'(active), 64'(0));
        drive(1'b1, 1'b1, 1'b0, 4'b0000, 40'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_release_enable", 64'(enable), 64'(0));
        end

        // Reset during CRASH aborts it at once.
        drive(1'b1, 1'b1, 1'b1, 4'b0000, 40'b0);
        repeat (SPAWN_TICKS) step();
        check("rcrash_spawn", 64'(active), 64'(4'b0001));
        drive(1'b1, 1'b1, 1'b0, 4'b0001, 40'b0);
        step();
        check("rcrash_enter", 64'(crash), 64'(1));
        drive(1'b1, 1'b1, 1'b1, 4'b0000, 40'b0);
        repeat (10) step();
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 40'b0);
        step();
        check("rcrash_crash", 64'(crash), 64'(0));
        check("rcrash_active", 64'(active), 64'(0));
        check("rcrash_score", 64'(score), 64'(0));
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 40'b0);
        repeat (2) step();
        check("rcrash_idle_crash", 64'(crash), 64'(0));
        check("rcrash_idle_enable", 64'(enable), 64'(0));

        // Randomized phase against the model.
        for (int c = 0; c < 6000; c++) begin
            py_r = '0;
            for (int k = 0; k < 4; k++) begin
                r = int'($urandom_range(0, 15));
                if (r == 0)      val = 479;
                else if (r == 1) val = 480;
                else if (r < 4)  val = int'($urandom_range(481, 1023));
                else             val = int'($urandom_range(0, 478));
                py_r[10*k +: 10] = 10'(val);
            end
            drive(logic'($urandom_range(0, 499) != 0),
                  logic'($urandom_range(0, 99) != 0),
                  logic'($urandom_range(0, 3) != 0),
                  {logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 199) == 0),
                   logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 199) == 0)},
                  py_r);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
